// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter
// Description : Shares one frame-buffer BRAM port between display reads
//               (priority) and the image writer (bounded starvation).
//               Optional build macro FB_ARB_STATS_EN adds stall/forced counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              disp_miss,
    input  logic              miss_clr
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       wr_stall_cnt,
    output logic [15:0]       forced_cnt
`endif
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_WR   = 2'd2
    } grant_state_t;

    grant_state_t      r_last_grant;
    grant_state_t      w_next_grant;
    logic              r_last_forced;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_cnt_nxt;
    logic              w_disp_gnt;
    logic              w_wr_gnt;
    logic              w_forced;
    logic              w_after_forced;
    logic              w_wr_stall;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic              r_disp_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant  <= S_IDLE;
            r_last_forced <= 1'b0;
            r_wait_cnt    <= 8'd0;
        end else begin
            r_last_grant  <= w_next_grant;
            r_last_forced <= w_forced;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    // Grants are suppressed during rst so nothing reaches the BRAM in reset.
    always_comb begin
        w_disp_gnt     = 1'b0;
        w_wr_gnt       = 1'b0;
        w_forced       = 1'b0;
        w_after_forced = (r_last_grant == S_WR) && r_last_forced;
        if (!rst) begin
            if (disp_req && wr_req) begin
                if ((r_wait_cnt == c_max_wait) && !w_after_forced) begin
                    w_wr_gnt = 1'b1;
                    w_forced = 1'b1;
                end else begin
                    w_disp_gnt = 1'b1;
                end
            end else begin
                w_disp_gnt = disp_req;
                w_wr_gnt   = wr_req;
            end
        end
        w_next_grant = w_disp_gnt ? S_DISP : (w_wr_gnt ? S_WR : S_IDLE);
        w_wr_stall   = wr_req && !w_wr_gnt;
        if (w_wr_stall) begin
            w_wait_cnt_nxt = (r_wait_cnt == c_max_wait) ? r_wait_cnt : r_wait_cnt + 8'd1;
        end else begin
            w_wait_cnt_nxt = 8'd0;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_rd_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_rd_pipe <= '0;
                else     r_rd_pipe <= w_disp_gnt;
            end
        end else begin : g_rd_latn
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_rd_pipe <= '0;
                else     r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], w_disp_gnt};
            end
        end
    endgenerate

    // A denial in the same cycle as a clear must not be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_miss <= 1'b0;
        end else if (disp_req && !w_disp_gnt) begin
            r_disp_miss <= 1'b1;
        end else if (miss_clr) begin
            r_disp_miss <= 1'b0;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_wr_stall_cnt;
    logic [15:0] r_forced_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_stall_cnt <= 16'd0;
            r_forced_cnt   <= 16'd0;
        end else if (miss_clr) begin
            r_wr_stall_cnt <= 16'd0;
            r_forced_cnt   <= 16'd0;
        end else begin
            if (w_wr_stall && (r_wr_stall_cnt != 16'hFFFF)) r_wr_stall_cnt <= r_wr_stall_cnt + 16'd1;
            if (w_forced && (r_forced_cnt != 16'hFFFF))     r_forced_cnt   <= r_forced_cnt + 16'd1;
        end
    end

    assign wr_stall_cnt = r_wr_stall_cnt;
    assign forced_cnt   = r_forced_cnt;
`endif

    assign disp_gnt   = w_disp_gnt;
    assign wr_gnt     = w_wr_gnt;
    assign bram_en    = w_disp_gnt | w_wr_gnt;
    assign bram_we    = w_wr_gnt;
    assign bram_addr  = w_wr_gnt ? wr_addr : (w_disp_gnt ? disp_addr : '0);
    assign bram_din   = w_wr_gnt ? wr_data : '0;
    assign disp_valid = r_rd_pipe[RD_LAT-1];
    assign disp_data  = disp_valid ? bram_dout : '0;
    assign disp_miss  = r_disp_miss;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_port_arbiter
// Description : Self-checking bench; two arbiters (read latency 1 and 2) share
//               stimulus. Build with FB_ARB_STATS_EN to also check counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int MASK     = 8191;

    logic        clk;
    logic        rst;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        miss_clr;

    logic        disp_gnt1, disp_valid1, wr_gnt1, bram_en1, bram_we1, disp_miss1;
    logic [11:0] disp_data1, bram_din1, bram_dout1;
    logic [18:0] bram_addr1;
    logic        disp_gnt2, disp_valid2, wr_gnt2, bram_en2, bram_we2, disp_miss2;
    logic [11:0] disp_data2, bram_din2, bram_dout2;
    logic [18:0] bram_addr2;
`ifdef FB_ARB_STATS_EN
    logic [15:0] wr_stall_cnt1, forced_cnt1, wr_stall_cnt2, forced_cnt2;
`endif

    fb_port_arbiter #(.DATA_W(12), .ADDR_W(19), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut1 (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt1),
        .disp_valid(disp_valid1), .disp_data(disp_data1),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt1),
        .bram_en(bram_en1), .bram_we(bram_we1), .bram_addr(bram_addr1),
        .bram_din(bram_din1), .bram_dout(bram_dout1),
        .disp_miss(disp_miss1), .miss_clr(miss_clr)
`ifdef FB_ARB_STATS_EN
        , .wr_stall_cnt(wr_stall_cnt1), .forced_cnt(forced_cnt1)
`endif
    );

    fb_port_arbiter #(.DATA_W(12), .ADDR_W(19), .RD_LAT(2), .MAX_WAIT(MAX_WAIT)) dut2 (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt2),
        .disp_valid(disp_valid2), .disp_data(disp_data2),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt2),
        .bram_en(bram_en2), .bram_we(bram_we2), .bram_addr(bram_addr2),
        .bram_din(bram_din2), .bram_dout(bram_dout2),
        .disp_miss(disp_miss2), .miss_clr(miss_clr)
`ifdef FB_ARB_STATS_EN
        , .wr_stall_cnt(wr_stall_cnt2), .forced_cnt(forced_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] f(input logic [18:0] a);
        return a[11:0] + 12'h100;
    endfunction

    // Behavioural BRAM: returns f(address) after the instance's read latency.
    logic [11:0] bp1, bp2a, bp2b;
    always @(posedge clk) begin
        bp1  <= f(bram_addr1);
        bp2a <= f(bram_addr2);
        bp2b <= bp2a;
    end
    assign bram_dout1 = bp1;
    assign bram_dout2 = bp2b;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rst = -100;
    int m_wait = 0;
    bit m_forced = 0;
    bit m_miss = 0;
    int m_stall = 0;
    int m_fcnt = 0;
    bit m_dg = 0;
    bit m_wg = 0;
    bit          gh[8192];
    logic [18:0] ah[8192];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic dreq, input logic [18:0] daddr, input logic wreq,
                         input logic [18:0] waddr, input logic [11:0] wdata,
                         input logic clr, input logic rs);
        disp_req  = dreq;
        disp_addr = daddr;
        wr_req    = wreq;
        wr_addr   = waddr;
        wr_data   = wdata;
        miss_clr  = clr;
        rst       = rs;
    endtask

    // Called at the negedge: compare against the reference, advance it, move to next cycle.
    task automatic finish_cycle();
        bit dg, wg, fz, v1, v2;
        logic [18:0] ea;
        logic [11:0] ed, d1, d2;
        dg = 0; wg = 0; fz = 0;
        if (!rst) begin
            if (disp_req && wr_req) begin
                if (!m_forced && m_wait == MAX_WAIT) begin wg = 1; fz = 1; end
                else dg = 1;
            end else begin
                dg = disp_req;
                wg = wr_req;
            end
        end
        ea = wg ? wr_addr : (dg ? disp_addr : 19'h0);
        ed = wg ? wr_data : 12'h0;
        v1 = !rst && cyc >= 1 && gh[(cyc-1) & MASK] && last_rst <= cyc - 1;
        v2 = !rst && cyc >= 2 && gh[(cyc-2) & MASK] && last_rst <= cyc - 2;
        d1 = v1 ? f(ah[(cyc-1) & MASK]) : 12'h0;
        d2 = v2 ? f(ah[(cyc-2) & MASK]) : 12'h0;
        chk("gnt1", {disp_gnt1, wr_gnt1}, {dg, wg});
        chk("gnt2", {disp_gnt2, wr_gnt2}, {dg, wg});
        chk("bram1", {bram_en1, bram_we1, bram_addr1, bram_din1}, {dg | wg, wg, ea, ed});
        chk("bram2", {bram_en2, bram_we2, bram_addr2, bram_din2}, {dg | wg, wg, ea, ed});
        chk("rd1", {disp_valid1, disp_data1}, {v1, d1});
        chk("rd2", {disp_valid2, disp_data2}, {v2, d2});
        chk("miss1", disp_miss1, rst ? 1'b0 : m_miss);
        chk("miss2", disp_miss2, rst ? 1'b0 : m_miss);
`ifdef FB_ARB_STATS_EN
        chk("stats1", {wr_stall_cnt1, forced_cnt1}, rst ? 32'h0 : {16'(m_stall), 16'(m_fcnt)});
        chk("stats2", {wr_stall_cnt2, forced_cnt2}, rst ? 32'h0 : {16'(m_stall), 16'(m_fcnt)});
`endif
        gh[cyc & MASK] = dg;
        ah[cyc & MASK] = disp_addr;
        if (rst) begin
            m_wait = 0; m_forced = 0; m_miss = 0; m_stall = 0; m_fcnt = 0;
            last_rst = cyc;
        end else begin
            if (wr_req && !wg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else               m_wait = 0;
            m_forced = fz;
            if (disp_req && !dg) m_miss = 1;
            else if (miss_clr)   m_miss = 0;
            if (miss_clr) begin
                m_stall = 0; m_fcnt = 0;
            end else begin
                if (wr_req && !wg && m_stall < 65535) m_stall++;
                if (fz && m_fcnt < 65535) m_fcnt++;
            end
        end
        m_dg = dg;
        m_wg = wg;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        dreq;
        logic [18:0] daddr;
        logic        wreq;
        logic [18:0] waddr;
        logic [11:0] wdata;
        logic        clr;
        logic        e_dg, e_wg, e_we;
        logic [18:0] e_addr;
        logic [11:0] e_din;
        logic        e_miss;
        logic        chk_rd, e_v1;
        logic [11:0] e_d1;
        logic        chk_st;
        logic [15:0] e_stall, e_fcnt;
    } vec_t;

    vec_t tbl[50];

    initial begin
        vec_t r;
        int k;
        bit fz;
        bit rq_d, rq_w;
        logic [18:0] rq_da, rq_wa;
        logic [11:0] rq_wd;

        // Rows 0-26 and 28-36: both requesting; 27 writer only; 37-38 clear; 39-49 display stream.
        for (int i = 0; i < 50; i++) begin
            tbl[i] = '{default: '0};
            if (i <= 26 || (i >= 28 && i <= 36)) begin
                k  = (i <= 26) ? (i % 9) : (i - 28);
                fz = (k == 8);
                tbl[i].dreq  = 1; tbl[i].daddr = 19'(i);
                tbl[i].wreq  = 1; tbl[i].waddr = 19'h12345; tbl[i].wdata = 12'hABC;
                tbl[i].clr   = (i == 36);
                tbl[i].e_dg  = !fz; tbl[i].e_wg = fz; tbl[i].e_we = fz;
                tbl[i].e_addr = fz ? 19'h12345 : 19'(i);
                tbl[i].e_din  = fz ? 12'hABC : 12'h0;
                tbl[i].e_miss = (i >= 9);
            end else if (i == 27) begin
                tbl[i].wreq = 1; tbl[i].waddr = 19'h12345; tbl[i].wdata = 12'hABC;
                tbl[i].e_wg = 1; tbl[i].e_we = 1;
                tbl[i].e_addr = 19'h12345; tbl[i].e_din = 12'hABC;
                tbl[i].e_miss = 1;
                tbl[i].chk_st = 1; tbl[i].e_stall = 16'd24; tbl[i].e_fcnt = 16'd3;
            end else if (i == 37) begin
                tbl[i].clr = 1; tbl[i].e_miss = 1;
            end else if (i == 38) begin
                tbl[i].e_miss = 0; tbl[i].chk_st = 1;
            end else begin
                tbl[i].chk_rd = 1;
                tbl[i].e_v1   = (i >= 40);
                tbl[i].e_d1   = (i >= 40) ? 12'(12'h100 + (i - 40)) : 12'h0;
                if (i <= 48) begin
                    tbl[i].dreq = 1; tbl[i].daddr = 19'(i - 39);
                    tbl[i].e_dg = 1; tbl[i].e_addr = 19'(i - 39);
                end
            end
        end

        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            finish_cycle();
        end

        for (int i = 0; i < 50; i++) begin
            r = tbl[i];
            drive(r.dreq, r.daddr, r.wreq, r.waddr, r.wdata, r.clr, 1'b0);
            @(negedge clk);
            chk("tbl_gnt", {disp_gnt1, wr_gnt1, disp_gnt2, wr_gnt2}, {r.e_dg, r.e_wg, r.e_dg, r.e_wg});
            chk("tbl_bram", {bram_en1, bram_we1, bram_addr1, bram_din1},
                {r.e_dg | r.e_wg, r.e_we, r.e_addr, r.e_din});
            chk("tbl_miss", disp_miss1, r.e_miss);
            if (r.chk_rd) chk("tbl_rd1", {disp_valid1, disp_data1}, {r.e_v1, r.e_d1});
`ifdef FB_ARB_STATS_EN
            if (r.chk_st) chk("tbl_stats", {wr_stall_cnt1, forced_cnt1}, {r.e_stall, r.e_fcnt});
`endif
            finish_cycle();
        end

        // Reset with reads in flight and a partly-starved writer.
        for (int i = 0; i < 5; i++) begin
            drive(1, 19'(32'h100 + i), 1, 19'h2AAAA, 12'h555, 0, 0);
            @(negedge clk);
            finish_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 19'h105, 1, 19'h2AAAA, 12'h555, 0, 1);
            @(negedge clk);
            chk("rst_outs1", {disp_gnt1, wr_gnt1, bram_en1, bram_we1, bram_addr1, bram_din1,
                              disp_valid1, disp_data1, disp_miss1}, 64'h0);
            chk("rst_outs2", {disp_gnt2, wr_gnt2, bram_en2, bram_we2, bram_addr2, bram_din2,
                              disp_valid2, disp_data2, disp_miss2}, 64'h0);
            finish_cycle();
        end
        for (int i = 0; i < 9; i++) begin
            drive(1, 19'(32'h200 + i), 1, 19'h2AAAA, 12'h555, 0, 0);
            @(negedge clk);
            chk("post_rst_wr", wr_gnt2, (i == 8));
            chk("post_rst_v2", disp_valid2, (i >= 2));
            chk("post_rst_v1", disp_valid1, (i >= 1));
            finish_cycle();
        end

        // Randomised traffic honouring the hold-until-grant handshake.
        rq_d = 0; rq_w = 0; rq_da = 0; rq_wa = 0; rq_wd = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!rq_d || m_dg) begin
                rq_d  = ($urandom_range(0, 9) < 8);
                rq_da = 19'($urandom);
            end
            if (!rq_w || m_wg) begin
                rq_w  = 1'($urandom_range(0, 1));
                rq_wa = 19'($urandom);
                rq_wd = 12'($urandom);
            end
            drive(rq_d, rq_da, rq_w, rq_wa, rq_wd,
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 149) == 0));
            @(negedge clk);
            finish_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
